// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 12-key keypad scanner: FSM states, select codes, counter width.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package keypad_scanner_pkg;

   // Width of the dwell and debounce counters (both parameters top out at 255)
   localparam int CNT_W = 8;

   // Scanner FSM states
   typedef enum logic [1:0] {
      ST_SCAN    = 2'd0,
      ST_CONFIRM = 2'd1,
      ST_HELD    = 2'd2
   } state_t;

   // Select codes driven onto the keypad mux B_in
   localparam logic [3:0] KEY_D1    = 4'h0;
   localparam logic [3:0] KEY_D2    = 4'h1;
   localparam logic [3:0] KEY_D3    = 4'h2;
   localparam logic [3:0] KEY_D4    = 4'h3;
   localparam logic [3:0] KEY_D5    = 4'h4;
   localparam logic [3:0] KEY_D6    = 4'h5;
   localparam logic [3:0] KEY_D7    = 4'h6;
   localparam logic [3:0] KEY_D8    = 4'h7;
   localparam logic [3:0] KEY_D9    = 4'h8;
   localparam logic [3:0] KEY_STAR  = 4'h9;
   localparam logic [3:0] KEY_D0    = 4'hA;
   localparam logic [3:0] KEY_SHARP = 4'hB;
   localparam logic [3:0] KEY_LAST  = 4'hB;

   // Next select code in scan order; anything at or past the last key wraps to the first,
   // so the select bus can never escape the 0x0..0xB window.
   function automatic logic [3:0] next_code(input logic [3:0] code);
      if (code >= KEY_LAST) begin
         return KEY_D1;
      end
      return code + 4'd1;
   endfunction

endpackage

// File: rtl/keypad_scanner_evt_reg.sv
// One-entry valid/ready event register with overrun detection.
// Latency: an incoming event is visible on o_vld/o_dat one clock after i_evt_vld.
// Backpressure: held entry stays stable until o_vld & i_rdy; a new event arriving while full and not being drained is dropped and o_overrun pulses for one cycle.
module keypad_evt_reg #(
   parameter int DAT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_evt_vld,
   input  logic [DAT_W-1:0] i_evt_dat,
   input  logic             i_rdy,
   output logic             o_vld,
   output logic [DAT_W-1:0] o_dat,
   output logic             o_overrun
);

   logic             r_vld;
   logic [DAT_W-1:0] r_dat;
   logic             r_ovr;

   logic             w_accept;
   logic             w_load;
   logic             w_drop;

   // A handshake this cycle frees the slot, so a same-cycle event may take it over
   assign w_accept = r_vld & i_rdy;
   assign w_load   = i_evt_vld & (~r_vld | w_accept);
   assign w_drop   = i_evt_vld & r_vld & ~i_rdy;

   // Slot update: load wins over drain, drain clears, overrun is a registered one-cycle pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= 1'b0;
         r_dat <= '0;
         r_ovr <= 1'b0;
      end else begin
         r_ovr <= w_drop;
         if (w_load) begin
            r_vld <= 1'b1;
            r_dat <= i_evt_dat;
         end else if (w_accept) begin
            r_vld <= 1'b0;
         end
      end
   end

   assign o_vld     = r_vld;
   assign o_dat     = r_dat;
   assign o_overrun = r_ovr;

endmodule

// File: rtl/keypad_scanner.sv
// 12-key keypad scanner: walks select codes, debounces the selected key, posts press (and optionally release) events. Optional macro KEYPAD_RELEASE_EVT_EN adds key_release.
// Latency: press visible on key_valid DEB_CNT*DWELL+1 cycles after the key's select code is applied.
// Backpressure: one-entry event slot; events arriving while the slot is full and not drained are dropped with a one-cycle overrun pulse.
module keypad_scanner
   import keypad_scanner_pkg::*;
#(
   parameter int DWELL   = 4,
   parameter int DEB_CNT = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   output logic [3:0] B_sel,
   input  logic       key_in,
   output logic       key_valid,
   input  logic       key_ready,
   output logic [3:0] key_code,
   output logic       overrun
`ifdef KEYPAD_RELEASE_EVT_EN
   ,
   output logic       key_release
`endif
);

   // Terminal values of the two counters, sized to the shared counter width
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
   localparam logic [CNT_W-1:0] DEB_TGT    = CNT_W'(DEB_CNT);

`ifdef KEYPAD_RELEASE_EVT_EN
   localparam int EVT_W = 5;
`else
   localparam int EVT_W = 4;
`endif

   state_t           r_state;
   logic [3:0]       r_sel;
   logic [CNT_W-1:0] r_dwell;
   logic [CNT_W-1:0] r_deb;
   logic             r_evt;
   logic [3:0]       r_evt_code;
`ifdef KEYPAD_RELEASE_EVT_EN
   logic             r_evt_rel;
`endif

   logic             w_sample;
   logic [CNT_W-1:0] w_deb_inc;
   logic [EVT_W-1:0] w_evt_dat;
   logic [EVT_W-1:0] w_out_dat;
   logic             w_out_vld;
   logic             w_out_ovr;

   // key_in is only trusted on the last cycle of the dwell, after the mux has settled
   assign w_sample  = (r_dwell == DWELL_LAST);
   assign w_deb_inc = r_deb + 1'b1;

   // Scan/debounce FSM; the event strobe and its code are registered so the select
   // code may move on in the same edge that produces a release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_SCAN;
         r_sel      <= KEY_D1;
         r_dwell    <= '0;
         r_deb      <= '0;
         r_evt      <= 1'b0;
         r_evt_code <= KEY_D1;
`ifdef KEYPAD_RELEASE_EVT_EN
         r_evt_rel  <= 1'b0;
`endif
      end else begin
         r_evt <= 1'b0;
         if (!enable) begin
            // Freeze: select code holds, any candidate or held key is forgotten
            r_state <= ST_SCAN;
            r_dwell <= '0;
            r_deb   <= '0;
         end else if (!w_sample) begin
            r_dwell <= r_dwell + 1'b1;
         end else begin
            r_dwell <= '0;
            case (r_state)
               ST_SCAN: begin
                  if (key_in) begin
                     if (DEB_CNT == 1) begin
                        r_evt      <= 1'b1;
                        r_evt_code <= r_sel;
`ifdef KEYPAD_RELEASE_EVT_EN
                        r_evt_rel  <= 1'b0;
`endif
                        r_deb      <= '0;
                        r_state    <= ST_HELD;
                     end else begin
                        r_deb      <= 8'd1;
                        r_state    <= ST_CONFIRM;
                     end
                  end else begin
                     r_sel <= next_code(r_sel);
                  end
               end
               ST_CONFIRM: begin
                  if (!key_in) begin
                     // Bounce: drop the candidate and keep scanning
                     r_deb   <= '0;
                     r_state <= ST_SCAN;
                     r_sel   <= next_code(r_sel);
                  end else if (w_deb_inc == DEB_TGT) begin
                     r_evt      <= 1'b1;
                     r_evt_code <= r_sel;
`ifdef KEYPAD_RELEASE_EVT_EN
                     r_evt_rel  <= 1'b0;
`endif
                     r_deb      <= '0;
                     r_state    <= ST_HELD;
                  end else begin
                     r_deb <= w_deb_inc;
                  end
               end
               ST_HELD: begin
                  if (key_in) begin
                     r_deb <= '0;
                  end else if (w_deb_inc == DEB_TGT) begin
`ifdef KEYPAD_RELEASE_EVT_EN
                     r_evt      <= 1'b1;
                     r_evt_code <= r_sel;
                     r_evt_rel  <= 1'b1;
`endif
                     r_deb   <= '0;
                     r_state <= ST_SCAN;
                     r_sel   <= next_code(r_sel);
                  end else begin
                     r_deb <= w_deb_inc;
                  end
               end
               default: begin
                  r_deb   <= '0;
                  r_state <= ST_SCAN;
               end
            endcase
         end
      end
   end

`ifdef KEYPAD_RELEASE_EVT_EN
   assign w_evt_dat = {r_evt_rel, r_evt_code};
`else
   assign w_evt_dat = r_evt_code;
`endif

   keypad_evt_reg #(
      .DAT_W(EVT_W)
   ) u_evt_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_evt_vld (r_evt),
      .i_evt_dat (w_evt_dat),
      .i_rdy     (key_ready),
      .o_vld     (w_out_vld),
      .o_dat     (w_out_dat),
      .o_overrun (w_out_ovr)
   );

   assign B_sel     = r_sel;
   assign key_valid = w_out_vld;
   assign key_code  = w_out_dat[3:0];
   assign overrun   = w_out_ovr;
`ifdef KEYPAD_RELEASE_EVT_EN
   assign key_release = w_out_dat[4];
`endif

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter DWELL, default 4, clock cycles each select code is held before key_in is sampled (range 2..255).
REQ-002 Parameter DEB_CNT, default 8, consecutive equal samples required to accept a press or a release (range 1..255).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 enable  input  1  scanning enable; low freezes scanning.
REQ-006 B_sel  output  4  select code driven to the 12-key mux B_in.
REQ-007 key_in  input  1  mux D_out for the current B_sel; 1 means the key is pressed.
REQ-008 key_valid  output  1  event available.
REQ-009 key_ready  input  1  consumer accepts the event when key_valid and key_ready are both high at a clock edge.
REQ-010 key_code  output  4  select code of the event key.
REQ-011 overrun  output  1  one-cycle pulse when an event is dropped.

Function
REQ-012 Code map: 0x0-0x7 = D1-D8; 0x8 = D9; 0x9 = D_star; 0xA = D0; 0xB = D_sharp; B_sel never leaves 0x0..0xB.
REQ-013 A dwell counter runs 0..DWELL-1 while B_sel is stable, and key_in is sampled only at the edge where the counter equals DWELL-1.
REQ-014 FSM states: SCAN, CONFIRM, HELD.
REQ-015 SCAN: a sample of 0 advances B_sel (0xB wraps to 0x0) and restarts the dwell; a sample of 1 holds B_sel, sets the debounce count to 1 and enters CONFIRM.
REQ-016 CONFIRM: each sample of 1 increments the count; on reaching DEB_CNT, a press event is produced and the FSM enters HELD with the count cleared.
REQ-017 CONFIRM: a sample of 0 discards the candidate, returns to SCAN and advances B_sel.
REQ-018 With DEB_CNT=1, the first sample of 1 produces the event directly from SCAN and enters HELD.
REQ-019 HELD: B_sel is held and consecutive samples of 0 are counted; a sample of 1 clears the count.
REQ-020 HELD: on reaching DEB_CNT zero samples, the FSM returns to SCAN and advances B_sel.
REQ-021 Only one key is tracked at a time; other keys are not observed outside SCAN.
REQ-022 Event register, one entry: an event loads key_code and sets key_valid the cycle after the accepting sample edge.
REQ-023 key_valid and key_code stay stable until accepted; an accepting handshake clears key_valid on the next edge.
REQ-024 If an event arrives while key_valid is high and no handshake occurs that cycle, the new event is dropped, the held event is kept and overrun pulses for one cycle.
REQ-025 If an event arrives in the same cycle as an accepting handshake, the new event is loaded and key_valid stays high.
REQ-026 enable low forces SCAN, clears the dwell and debounce counters and holds B_sel at its current value; a pending event stays held and the handshake still works.
REQ-027 Minimum press latency from a stable key_in=1 to key_valid is DEB_CNT*DWELL+1 cycles after that key's select code is applied.

Reset
REQ-028 While rst_n is low: FSM=SCAN, B_sel=0x0, all counters 0, key_valid=0, key_code=0x0, overrun=0.
REQ-029 Reset asserted mid-operation discards any candidate, held key or pending event immediately, without waiting for a clock edge.

Configuration
REQ-030 With KEYPAD_RELEASE_EVT_EN defined: a 1-bit output key_release is added, and the HELD-to-SCAN transition posts a release event (key_release=1, same key_code) using the REQ-022..025 rules; press events carry key_release=0.
REQ-031 Without KEYPAD_RELEASE_EVT_EN: the key_release port does not exist and only press events are produced.

Structure
REQ-032 A shared package holds the FSM state enum, the code constants (KEY_D1=0x0 .. KEY_SHARP=0xB, KEY_LAST=0xB) and the 8-bit counter width.
REQ-033 One sub-module, keypad_evt_reg (the one-entry valid/ready event register with overrun detection), is instantiated once.

Verification
REQ-034 Hold key 0x5 at 1 with DWELL=4, DEB_CNT=8 -> exactly one event, key_code=0x5; key_valid rises 33 cycles after B_sel=0x5; no repeat while held.
REQ-035 Bounce key 0x3 as 1,1,0 on successive samples -> no event; B_sel advances to 0x4.
REQ-036 Idle keypad -> B_sel runs 0x0..0xB, each code held 4 cycles, then wraps to 0x0; never reaches 0xC.
REQ-037 Hold key_ready=0, then press 0x2, release it, press 0x7 -> key_code stays 0x2 and overrun pulses once; a later handshake clears key_valid.
REQ-038 Assert rst_n low while in HELD with key_valid high -> all outputs read reset values immediately.
REQ-039 With KEYPAD_RELEASE_EVT_EN, press and release 0xB -> two events, (0xB, release=0) then (0xB, release=1).
